// File: rtl/xnor_cla_adder16_aor_enc32_pkg.sv
// Shared constants for the key-locked 16-bit XNOR carry-lookahead adder.
//   KEY_W       : width of the locking key
//   OP_W        : operand width
//   RES_W       : result width (carry-out in the MSB)
//   CORRECT_KEY : the unlocking key; bit k selects an AND (1) or OR (0) gate
package xnor_cla_adder16_aor_enc32_pkg;

    localparam int KEY_W = 32;
    localparam int OP_W  = 16;
    localparam int RES_W = OP_W + 1;

    localparam logic [KEY_W-1:0] CORRECT_KEY = 32'h7641831B;

endpackage

// File: rtl/xnor_cla_adder16_aor_enc32_cla4_block.sv
// 4-bit carry-lookahead slice.
//   p[3:0], g[3:0] : (locked) per-bit propagate / generate
//   cin            : carry into bit 0 of the slice
//   s[3:0]         : sum bits
//   grp_p, grp_g   : group propagate / generate for the second-level lookahead
module cla4_block (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] s,
    output logic       grp_p,
    output logic       grp_g
);

    logic c1, c2, c3;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    // XNOR-style sum: ~(p ~^ c) is p ^ c
    assign s = ~(p ~^ {c3, c2, c1, cin});

endmodule

// File: rtl/xnor_cla_adder16_aor_enc32.sv
// Key-locked 16-bit XNOR carry-lookahead adder with a registered result.
//   clk_i    : clock, all state on the rising edge
//   rst_i    : synchronous active-high reset, clears result_o
//   add1_i   : operand A
//   add2_i   : operand B
//   keyinput : locking key; CORRECT_KEY gives result_o = add1_i + add2_i
//   result_o : registered {carry_out, sum[15:0]}
module xnor_cla_adder16_aor_enc32
    import xnor_cla_adder16_aor_enc32_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  add1_i,
    input  logic [OP_W-1:0]  add2_i,
    input  logic [KEY_W-1:0] keyinput,
    output logic [RES_W-1:0] result_o
);

    logic [OP_W-1:0] p_raw, g_raw;
    logic [OP_W-1:0] p_lk, g_lk;
    logic [OP_W-1:0] sum;
    logic [3:0]      grp_p, grp_g;
    logic [4:0]      gc;   // carries c0, c4, c8, c12, c16

    assign p_raw = ~(add1_i ~^ add2_i);
    assign g_raw = add1_i & add2_i;

    // Key bit i locks p_i, key bit 16+i locks g_i. The gate type is chosen so
    // the correct key bit is the identity element (1 for AND, 0 for OR).
    for (genvar i = 0; i < OP_W; i++) begin : g_key
        if (CORRECT_KEY[i]) begin : g_p_and
            assign p_lk[i] = p_raw[i] & keyinput[i];
        end else begin : g_p_or
            assign p_lk[i] = p_raw[i] | keyinput[i];
        end
        if (CORRECT_KEY[OP_W+i]) begin : g_g_and
            assign g_lk[i] = g_raw[i] & keyinput[OP_W+i];
        end else begin : g_g_or
            assign g_lk[i] = g_raw[i] | keyinput[OP_W+i];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_cla
        cla4_block u_cla4 (
            .p     (p_lk[4*b +: 4]),
            .g     (g_lk[4*b +: 4]),
            .cin   (gc[b]),
            .s     (sum[4*b +: 4]),
            .grp_p (grp_p[b]),
            .grp_g (grp_g[b])
        );
    end

    // Second-level lookahead over the group P/G
    assign gc[0] = 1'b0;
    assign gc[1] = grp_g[0] | (grp_p[0] & gc[0]);
    assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & gc[0]);
    assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);
    assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
        end else begin
            result_o <= {gc[4], sum};
        end
    end

endmodule

// File: tb/tb_xnor_cla_adder16_aor_enc32.sv
module tb_xnor_cla_adder16_aor_enc32;

    localparam logic [31:0] GOOD_KEY = 32'h7641831B;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] add1_i, add2_i;
    logic [31:0] keyinput;
    logic [16:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    xnor_cla_adder16_aor_enc32 dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .add1_i   (add1_i),
        .add2_i   (add2_i),
        .keyinput (keyinput),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 17'h%05h, expected 17'h%05h", tag, obs, exp);
        end
    endtask

    // Reference: with the correct key it is plain addition; otherwise apply the
    // key-gate rules bit by bit and walk the carry recurrence.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [31:0] key);
        logic c;
        logic pk, gk;
        logic [15:0] s;
        if (key == GOOD_KEY) return {1'b0, a} + {1'b0, b};
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pk = a[i] ^ b[i];
            gk = a[i] & b[i];
            pk = GOOD_KEY[i]    ? (pk & key[i])    : (pk | key[i]);
            gk = GOOD_KEY[16+i] ? (gk & key[16+i]) : (gk | key[16+i]);
            s[i] = pk ^ c;
            c = gk | (pk & c);
        end
        return {c, s};
    endfunction

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k);
        @(negedge clk_i);
        add1_i   = a;
        add2_i   = b;
        keyinput = k;
        @(posedge clk_i);
        #1;
    endtask

    task automatic dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] k, input logic [16:0] exp);
        apply(a, b, k);
        chk(tag, result_o, exp);
    endtask

    initial begin
        logic [15:0] a, b;
        logic [31:0] k;
        logic [16:0] v;

        rst_i = 1'b1; add1_i = 16'hFFFF; add2_i = 16'hFFFF; keyinput = GOOD_KEY;
        @(posedge clk_i); #1;
        chk("reset", result_o, 17'h0);
        apply(16'h1234, 16'h4321, 32'hDEADBEEF);
        chk("reset_hold", result_o, 17'h0);
        rst_i = 1'b0;

        dir("add_29af_7a1b", 16'h29AF, 16'h7A1B, GOOD_KEY, 17'h0A3CA);
        dir("add_8943_ffff", 16'h8943, 16'hFFFF, GOOD_KEY, 17'h18942);
        dir("add_8051_8086", 16'h8051, 16'h8086, GOOD_KEY, 17'h100D7);
        dir("prop_chain",    16'h5555, 16'hAAAA, GOOD_KEY, 17'h0FFFF);
        dir("add_fadc_00dc", 16'hFADC, 16'h00DC, GOOD_KEY, 17'h0FBB8);
        dir("add_0_1",       16'h0000, 16'h0001, GOOD_KEY, 17'h00001);
        dir("wrap_max",      16'hFFFF, 16'hFFFF, GOOD_KEY, 17'h1FFFE);
        dir("zero",          16'h0000, 16'h0000, GOOD_KEY, 17'h00000);

        dir("key_all1", 16'h0000, 16'h0000, 32'hFFFFFFFF, ref_sum(16'h0000, 16'h0000, 32'hFFFFFFFF));
        apply(16'hFFFF, 16'h0001, 32'h00000000);
        chk("key_all0", result_o, ref_sum(16'hFFFF, 16'h0001, 32'h00000000));
        n_vec++;
        if (result_o === 17'h10000) begin
            n_err++;
            $display("FAIL key_all0_locked: got 17'h%05h, required anything but 17'h10000", result_o);
        end

        // Reset in mid-stream must override the datapath.
        @(negedge clk_i); rst_i = 1'b1; add1_i = 16'hFFFF; add2_i = 16'h0001;
        @(posedge clk_i); #1;
        chk("reset_mid", result_o, 17'h0);
        rst_i = 1'b0;

        // Single-bit key flips: each key gate individually must corrupt as modelled.
        for (int kb = 0; kb < 32; kb++) begin
            a = 16'($urandom); b = 16'($urandom);
            k = GOOD_KEY ^ (32'h1 << kb);
            dir($sformatf("keyflip_%0d", kb), a, b, k, ref_sum(a, b, k));
        end

        // Back-to-back random traffic: correct key, random keys, near-correct keys.
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    k = GOOD_KEY;
                2:       k = $urandom;
                default: k = GOOD_KEY ^ $urandom ^ $urandom;
            endcase
            v = ref_sum(a, b, k);
            dir("random", a, b, k, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
